fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 125 ++++++++++++
 tb/tb_fetch_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue sequencer: walks a registered-read ROM, strobes the
// processor Run for each instruction, and guards each execution with a watchdog.
module fetch_sequencer #(
  parameter int         ADDR_W  = 5,
  parameter logic [2:0] MVI_OP  = 3'b001,
  parameter int         TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Step,
  input  logic              Done,
  input  logic [8:0]        DIN,
  output logic [ADDR_W-1:0] Address,
  output logic              Run,
  output logic              Busy,
  output logic              Error,
  output logic [7:0]        InstrCount
);

  // state  | meaning
  // IDLE   | parked, Address = PC, waiting for Start/Step
  // FETCH  | Address = PC, ROM read in flight
  // ISSUE  | Run pulse, DIN = mem[PC]; Address moves to PC+1 for the operand word
  // EXEC   | waiting for Done, watchdog counting down
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_EXEC  = 2'd3
  } state_t;

  localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              cont, cont_nxt;
  logic              is_mvi, is_mvi_nxt;
  logic              error_q, error_nxt;
  logic [7:0]        count_q, count_nxt;
  logic [WD_W-1:0]   wd_cnt, wd_nxt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      cont    <= 1'b0;
      is_mvi  <= 1'b0;
      error_q <= 1'b0;
      count_q <= 8'd0;
      wd_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      cont    <= cont_nxt;
      is_mvi  <= is_mvi_nxt;
      error_q <= error_nxt;
      count_q <= count_nxt;
      wd_cnt  <= wd_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    is_mvi_nxt = is_mvi;
    error_nxt  = error_q;
    count_nxt  = count_q;
    wd_nxt     = wd_cnt;
    Address    = pc;
    Run        = 1'b0;

    // Stop beats Start whenever both arrive together
    if (Stop)       cont_nxt = 1'b0;
    else if (Start) cont_nxt = 1'b1;
    else            cont_nxt = cont;

    case (state)
      S_IDLE: begin
        if (Start && !Stop) begin
          state_nxt = S_FETCH;
          error_nxt = 1'b0;
        end else if (Step && !Start) begin
          state_nxt = S_FETCH;
          cont_nxt  = 1'b0;
          error_nxt = 1'b0;
        end
      end
      S_FETCH: begin
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        Run        = 1'b1;
        Address    = pc + ADDR_W'(1);
        is_mvi_nxt = (DIN[8:6] == MVI_OP);
        wd_nxt     = WD_LOAD;
        state_nxt  = S_EXEC;
      end
      S_EXEC: begin
        Address = pc + ADDR_W'(1);
        if (Done) begin
          pc_nxt    = pc + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));
          count_nxt = (count_q != 8'hFF) ? count_q + 8'd1 : count_q;
          state_nxt = cont_nxt ? S_FETCH : S_IDLE;
        end else if (wd_cnt == '0) begin
          error_nxt = 1'b1;
          cont_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          wd_nxt = wd_cnt - WD_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign Busy       = (state != S_IDLE);
  assign Error      = error_q;
  assign InstrCount = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: ROM model, Done responder, and a Run
// monitor that pops the expected PC of every issued instruction.
module tb_fetch_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       Stop  = 1'b0;
  logic       Step  = 1'b0;
  logic       Done  = 1'b0;
  logic [8:0] DIN;
  logic [4:0] Address;
  logic       Run;
  logic       Busy;
  logic       Error;
  logic [7:0] InstrCount;

  fetch_sequencer dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Stop       (Stop),
    .Step       (Step),
    .Done       (Done),
    .DIN        (DIN),
    .Address    (Address),
    .Run        (Run),
    .Busy       (Busy),
    .Error      (Error),
    .InstrCount (InstrCount)
  );

  always #5 Clock = ~Clock;

  logic [8:0] mem [32];
  always @(posedge Clock) DIN <= mem[Address];

  int n_chk  = 0;
  int n_pass = 0;
  int sb[$];
  int done_dly = 2;
  bit resp_en  = 1'b1;
  int exp_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic drive(input logic s_start, input logic s_stop, input logic s_step);
    @(posedge Clock); #1;
    Start = s_start; Stop = s_stop; Step = s_step;
    @(posedge Clock); #1;
    Start = 1'b0; Stop = 1'b0; Step = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge Clock); #1 Reset = 1'b1;
    @(posedge Clock); #1 Reset = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (Busy && n < max_cyc) begin
      @(negedge Clock);
      n++;
    end
    check("wait_idle", 32'(Busy), 0);
  endtask

  task automatic wait_drain(input int max_cyc, output logic saw_idle);
    int n = 0;
    saw_idle = 1'b0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge Clock); #1;
      if (!Busy) saw_idle = 1'b1;
      n++;
    end
    check("sb_drain", 32'(sb.size()), 0);
  endtask

  // Done responder: raises Done in the done_dly-th EXEC cycle after each Run
  initial forever begin
    @(negedge Clock);
    if (Run && resp_en) begin
      @(posedge Clock);
      repeat (done_dly - 1) @(posedge Clock);
      #1 Done = 1'b1;
      @(posedge Clock);
      #1 Done = 1'b0;
    end
  end

  // Run monitor: issue-cycle address/data, then processor T1 view
  initial forever begin
    @(negedge Clock);
    if (Run === 1'b1) begin
      if (sb.size() == 0) begin
        check("run_unexpected", 32'(Run), 0);
      end else begin
        exp_pc = sb.pop_front();
        check("issue_addr", 32'(Address), 32'((exp_pc + 1) % 32));
        check("issue_din", 32'(DIN), 32'(mem[exp_pc]));
        @(negedge Clock);
        check("t1_run_low", 32'(Run), 0);
        check("t1_din", 32'(DIN), 32'(mem[(exp_pc + 1) % 32]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic saw_idle;
    for (int i = 0; i < 32; i++) mem[i] = 9'(i);

    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    check("rst_addr",  32'(Address), 0);
    check("rst_run",   32'(Run), 0);
    check("rst_busy",  32'(Busy), 0);
    check("rst_error", 32'(Error), 0);
    check("rst_count", 32'(InstrCount), 0);

    // single step, non-MVI, Done in 2nd EXEC cycle
    done_dly = 2;
    sb.push_back(0);
    drive(0, 0, 1);
    check("fetch_addr", 32'(Address), 0);
    check("fetch_run",  32'(Run), 0);
    check("fetch_busy", 32'(Busy), 1);
    wait_idle(40);
    check("step_pc",    32'(Address), 1);
    check("step_count", 32'(InstrCount), 1);

    // single step over an MVI at address 0
    do_reset();
    mem[0] = {3'b001, 6'h15};
    sb.push_back(0);
    drive(0, 0, 1);
    wait_idle(40);
    check("mvi_pc",    32'(Address), 2);
    check("mvi_count", 32'(InstrCount), 1);
    mem[0] = 9'd0;

    // continuous run of 33 instructions, PC wraps 31 -> 0
    do_reset();
    done_dly = 3;
    for (int i = 0; i < 33; i++) sb.push_back(i % 32);
    drive(1, 0, 0);
    wait_drain(400, saw_idle);
    check("cont_busy_held", 32'(saw_idle), 0);
    drive(0, 1, 0);
    wait_idle(40);
    check("cont_pc",    32'(Address), 1);
    check("cont_count", 32'(InstrCount), 33);

    // MVI at PC=31, Stop during its EXEC
    do_reset();
    done_dly = 2;
    mem[31] = {3'b001, 6'h3F};
    for (int i = 0; i < 32; i++) sb.push_back(i);
    drive(1, 0, 0);
    wait_drain(400, saw_idle);
    drive(0, 1, 0);
    wait_idle(40);
    check("wrap_mvi_pc",    32'(Address), 1);
    check("wrap_mvi_count", 32'(InstrCount), 32);
    check("wrap_mvi_busy",  32'(Busy), 0);
    mem[31] = 9'd31;

    // InstrCount saturation over 260 instructions
    do_reset();
    done_dly = 1;
    for (int i = 0; i < 260; i++) sb.push_back(i % 32);
    drive(1, 0, 0);
    wait_drain(2000, saw_idle);
    drive(0, 1, 0);
    wait_idle(40);
    check("sat_count", 32'(InstrCount), 255);
    check("sat_pc",    32'(Address), 4);

    // watchdog timeout, then Step clears Error
    do_reset();
    done_dly = 2;
    resp_en = 1'b0;
    sb.push_back(0);
    drive(0, 0, 1);
    begin
      int n = 0;
      while (Busy && n < 40) begin
        @(negedge Clock);
        if (Busy) n++;
      end
      check("wd_busy_cycles", 32'(n), 17);
    end
    check("wd_error", 32'(Error), 1);
    check("wd_pc",    32'(Address), 0);
    check("wd_count", 32'(InstrCount), 0);
    repeat (3) @(negedge Clock);
    check("wd_error_sticky", 32'(Error), 1);
    resp_en = 1'b1;
    sb.push_back(0);
    drive(0, 0, 1);
    check("wd_error_clear", 32'(Error), 0);
    wait_idle(40);
    check("wd_retry_pc", 32'(Address), 1);

    // Start+Stop together in IDLE starts nothing
    do_reset();
    drive(1, 1, 0);
    repeat (4) @(negedge Clock);
    check("start_stop_busy", 32'(Busy), 0);

    // Reset during EXEC aborts the instruction
    sb.push_back(0);
    drive(0, 0, 1);
    wait_idle(40);
    check("pre_rst_pc", 32'(Address), 1);
    resp_en = 1'b0;
    sb.push_back(1);
    drive(0, 0, 1);
    wait_drain(20, saw_idle);
    @(posedge Clock); #1 Reset = 1'b1;
    @(posedge Clock); #1 Reset = 1'b0;
    check("exec_rst_busy",  32'(Busy), 0);
    check("exec_rst_addr",  32'(Address), 0);
    check("exec_rst_count", 32'(InstrCount), 0);
    check("exec_rst_run",   32'(Run), 0);
    resp_en = 1'b1;
    repeat (4) @(negedge Clock);
    check("sb_final", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
